// File: rtl/eight_one_mux_pkg.sv
// Shared constants and types for the registered 8:1 multiplexer.
// Optional parity output is enabled with EIGHT_ONE_MUX_PARITY_EN.
package eight_one_mux_pkg;

    localparam int MUX_WIDTH = 16;

    typedef logic [2:0] sel_t;

    localparam sel_t SEL_A = 3'd0;
    localparam sel_t SEL_B = 3'd1;
    localparam sel_t SEL_C = 3'd2;
    localparam sel_t SEL_D = 3'd3;
    localparam sel_t SEL_E = 3'd4;
    localparam sel_t SEL_F = 3'd5;
    localparam sel_t SEL_G = 3'd6;
    localparam sel_t SEL_H = 3'd7;

endpackage

// File: rtl/eight_one_mux_core.sv
// Purely combinational WIDTH-bit 8:1 select; every sel code maps to an input,
// so unselected inputs (even X) never reach the output.
module eight_one_mux_core
    import eight_one_mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (sel)
            SEL_A: y = a;
            SEL_B: y = b;
            SEL_C: y = c;
            SEL_D: y = d;
            SEL_E: y = e;
            SEL_F: y = f;
            SEL_G: y = g;
            SEL_H: y = h;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/eight_one_mux.sv
// Registered 8:1 multiplexer: one-cycle latency, en-qualified capture, y_valid
// flags enabled edges. EIGHT_ONE_MUX_PARITY_EN adds registered even parity y_par.
module eight_one_mux
    import eight_one_mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
`ifdef EIGHT_ONE_MUX_PARITY_EN
    ,
    output logic             y_par
`endif
);

    logic [WIDTH-1:0] sel_data;

    eight_one_mux_core #(.WIDTH(WIDTH)) u_core (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e),
        .f   (f),
        .g   (g),
        .h   (h),
        .sel (sel),
        .y   (sel_data)
    );

    // y holds across disabled edges; y_valid marks only freshly captured data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= en;
            if (en)
                y <= sel_data;
        end
    end

`ifdef EIGHT_ONE_MUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            y_par <= 1'b0;
        else if (en)
            y_par <= ^sel_data;
    end
`endif

endmodule

// File: tb/tb_eight_one_mux.sv
// Self-checking bench for eight_one_mux: table vectors plus hand sequences,
// expected results queued at drive time and checked one edge later.
module tb_eight_one_mux;
    import eight_one_mux_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n, en;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    sel_t         sel;
    logic [W-1:0] y;
    logic         y_valid;
`ifdef EIGHT_ONE_MUX_PARITY_EN
    logic         y_par;
`endif

    eight_one_mux #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .g       (g),
        .h       (h),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
`ifdef EIGHT_ONE_MUX_PARITY_EN
        ,
        .y_par   (y_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             en;
        sel_t             sel;
        logic [7:0][W-1:0] din;
        logic [W-1:0]     exp_y;
        logic             exp_v;
        logic             exp_par;
    } vec_t;

    typedef struct {
        logic [W-1:0] y;
        logic         v;
        logic         par;
        string        nm;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    logic [7:0][W-1:0] base;

    task automatic drive_in(input logic [7:0][W-1:0] dv);
        a = dv[0]; b = dv[1]; c = dv[2]; d = dv[3];
        e = dv[4]; f = dv[5]; g = dv[6]; h = dv[7];
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        x = sb.pop_front();
        total++;
        if (y !== x.y) begin
            bad++;
            $display("FAIL %s y actual=%0d required=%0d", x.nm, y, x.y);
        end
        total++;
        if (y_valid !== x.v) begin
            bad++;
            $display("FAIL %s y_valid actual=%0b required=%0b", x.nm, y_valid, x.v);
        end
`ifdef EIGHT_ONE_MUX_PARITY_EN
        total++;
        if (y_par !== x.par) begin
            bad++;
            $display("FAIL %s y_par actual=%0b required=%0b", x.nm, y_par, x.par);
        end
`endif
    endtask

    task automatic apply(input vec_t t, input string nm);
        exp_t x;
        rst_n = t.rst_n;
        en    = t.en;
        sel   = t.sel;
        drive_in(t.din);
        x.y = t.exp_y; x.v = t.exp_v; x.par = t.exp_par; x.nm = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    function automatic vec_t mk(input logic r, input logic en_i, input sel_t s,
                                input logic [7:0][W-1:0] dv, input logic [W-1:0] ey,
                                input logic ev, input logic ep);
        vec_t t;
        t.rst_n = r; t.en = en_i; t.sel = s; t.din = dv;
        t.exp_y = ey; t.exp_v = ev; t.exp_par = ep;
        return t;
    endfunction

    vec_t tbl[$];
    logic [W-1:0] sweep_exp [8] = '{16'd50, 16'd100, 16'd5000, 16'd10000,
                                    16'd12, 16'd2, 16'd9000, 16'd1234};

    initial begin
        logic [7:0][W-1:0] dv;
        base[0] = 16'd50;   base[1] = 16'd100;  base[2] = 16'd5000; base[3] = 16'd10000;
        base[4] = 16'd12;   base[5] = 16'd2;    base[6] = 16'd9000; base[7] = 16'd1234;

        // reset with data loaded and en high, then full sweep
        tbl.push_back(mk(1'b0, 1'b1, SEL_D, base, 16'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, SEL_H, base, 16'd0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 1'b1, sel_t'(i), base, sweep_exp[i], 1'b1, ^sweep_exp[i]));
        // hold: capture d, then en low with sel=7
        tbl.push_back(mk(1'b1, 1'b1, SEL_D, base, 16'd10000, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1'b1, 1'b0, SEL_H, base, 16'd10000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 1'b1, SEL_H, base, 16'd1234, 1'b1, 1'b1));
        // boundaries and parity cases
        dv = base; dv[0] = 16'h0000;
        tbl.push_back(mk(1'b1, 1'b1, SEL_A, dv, 16'h0000, 1'b1, 1'b0));
        dv = base; dv[7] = 16'hFFFF;
        tbl.push_back(mk(1'b1, 1'b1, SEL_H, dv, 16'hFFFF, 1'b1, 1'b0));
        dv = base; dv[2] = 16'h0003;
        tbl.push_back(mk(1'b1, 1'b1, SEL_C, dv, 16'h0003, 1'b1, 1'b0));
        // equal values on every input
        dv = {8{16'hA5A5}};
        tbl.push_back(mk(1'b1, 1'b1, SEL_F, dv, 16'hA5A5, 1'b1, 1'b0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // isolation: a=FFFF selected while every other input changes each cycle
        for (int i = 0; i < 6; i++) begin
            vec_t t;
            dv[0] = 16'hFFFF;
            for (int k = 1; k < 8; k++) dv[k] = W'($urandom);
            t = mk(1'b1, 1'b1, SEL_A, dv, 16'hFFFF, 1'b1, 1'b0);
            apply(t, $sformatf("iso%0d", i));
        end

        // sel/data wiggle between edges must not disturb y
        rst_n = 1'b1; en = 1'b1; sel = SEL_B; drive_in(base);
        @(posedge clk); #1;
        en = 1'b0;
        sel = SEL_G; b = 16'h1111;
        #3;
        total++;
        if (y !== 16'd100) begin
            bad++;
            $display("FAIL between_edges y actual=%0d required=%0d", y, 16'd100);
        end

        // reset mid-stream at sel=5, resume at sel=6
        for (int i = 0; i < 5; i++)
            apply(mk(1'b1, 1'b1, sel_t'(i), base, sweep_exp[i], 1'b1, ^sweep_exp[i]),
                  $sformatf("mid%0d", i));
        apply(mk(1'b0, 1'b1, SEL_F, base, 16'd0, 1'b0, 1'b0), "mid_rst");
        apply(mk(1'b1, 1'b1, SEL_G, base, 16'd9000, 1'b1, 1'b1), "mid_resume");
        apply(mk(1'b1, 1'b1, SEL_H, base, 16'd1234, 1'b1, 1'b1), "mid_next");

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eight_one_mux.md
Name: eight_one_mux

Overview:
- Registered 8-to-1 multiplexer. It selects one of eight WIDTH-bit data inputs (a..h) using a 3-bit binary select.
- The selected word is presented on y one clock after sampling.
- Used as a datapath operand/result selector (e.g. ALU writeback source select) in the CPU datapath.
- Single clock domain; synchronous active-low reset.

Parameters:
- WIDTH, 16, bit width of every data input and of y.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  sample enable; when high, the selected input is captured this edge.
- a  input  WIDTH  data input, selected by sel=0.
- b  input  WIDTH  data input, selected by sel=1.
- c  input  WIDTH  data input, selected by sel=2.
- d  input  WIDTH  data input, selected by sel=3.
- e  input  WIDTH  data input, selected by sel=4.
- f  input  WIDTH  data input, selected by sel=5.
- g  input  WIDTH  data input, selected by sel=6.
- h  input  WIDTH  data input, selected by sel=7.
- sel  input  3  binary select; all 8 codes are valid.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  high for exactly the cycles following an edge where en=1 was sampled.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Combinational select: sel 0..7 maps to a,b,c,d,e,f,g,h respectively. The decode is full, so no default/X path is possible.
- Rising edge with rst_n=0: y<=0 and y_valid<=0, regardless of en, sel or data.
- Rising edge with rst_n=1 and en=1: y<=selected input; y_valid<=1.
- Rising edge with rst_n=1 and en=0: y holds its previous value; y_valid<=0.
- Latency is exactly 1 cycle from sampled sel/data to y. Throughput is one selection per cycle; back-to-back sel changes are each reflected on consecutive cycles.
- Data is passed unmodified: no sign extension, truncation or arithmetic. Bit i of y equals bit i of the selected input.
- Changes to sel or to any data input between edges have no effect on y until the next enabled edge. There is no combinational path from inputs to outputs.
- Reset asserted mid-stream clears y on that edge. The first enabled edge after rst_n returns high produces valid data.
- Equal values on several inputs are not a special case: the output equals the indexed input.
- X/Z on unselected inputs must not propagate to y.

Optional Feature:
- Macro EIGHT_ONE_MUX_PARITY_EN.
- When defined: adds output y_par (1 bit), the registered even parity (XOR reduction) of the selected word.
  - y_par updates on the same edge as y, under the same en rule.
  - y_par resets to 0.
  - y_par holds when en=0.
- When undefined: port y_par does not exist; all other behaviour is identical.

Decomposition:
- Shared package eight_one_mux_pkg holds:
  - default width constant MUX_WIDTH=16;
  - select encoding constants SEL_A=3'd0 through SEL_H=3'd7;
  - a typedef for the 3-bit select.
- One natural sub-module: eight_one_mux_core. It is the purely combinational WIDTH-bit 8:1 select (case on sel), instantiated by eight_one_mux, which adds the output register, en/valid logic and optional parity.

Test Plan:
- Reset: rst_n=0 for 2 cycles with a..h loaded and en=1 -> y=0, y_valid=0. Release -> first enabled edge gives valid data.
- Full sweep:
  - Stimulus: a=50, b=100, c=5000, d=10000, e=12, f=2, g=9000, h=1234; en=1; sel stepped 0..7, one per cycle.
  - Required y one cycle later: 50, 100, 5000, 10000, 12, 2, 9000, 1234, with y_valid=1 each cycle.
- Hold: sel=3 captured (y=10000), then en=0 and sel=7 for 3 cycles -> y stays 10000, y_valid=0. Re-assert en -> y=1234.
- Isolation: sel=0, a=16'hFFFF, all other inputs toggled every cycle -> y stays 16'hFFFF. Boundary values: a=0 and h=16'hFFFF, each selected -> exact match.
- Reset mid-stream: during the sweep, assert rst_n=0 at sel=5 -> y=0 on that edge. Resume at sel=6 -> y=9000.
- Parity (EIGHT_ONE_MUX_PARITY_EN defined): sel=0 with a=50 gives y_par=1; sel=1 with b=100 gives y_par=1; sel=5 with f=2 gives y_par=1; c=16'h0003 selected gives y_par=0.
